// File: rtl/px_sched_pkg.sv
// Shared types and helpers for the metaball pixel scheduler.
// Optional build macro: PX_SCHED_COLOR_EN selects a four-level colour ramp
// instead of the default black/white map.
package px_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      GUARD,
      WAIT,
      WRITE,
      SWAP
   } state_t;

   // One integer pixel step in 17.15 fixed point.
   localparam logic [31:0] STEP = 32'h0000_8000;

   // RGB 4:4:4 colours used by the field-to-colour map.
   localparam logic [11:0] COL_WHITE  = 12'hfff;
   localparam logic [11:0] COL_ORANGE = 12'hf40;
   localparam logic [11:0] COL_DIM    = 12'h100;
   localparam logic [11:0] COL_BLACK  = 12'h000;

   // Maps a summed field value to a pixel colour. The 2*thresh comparison
   // is done at 33 bits so a large threshold never wraps.
   function automatic logic [11:0] color_map(input logic [31:0] field,
                                             input logic [31:0] thresh);
`ifdef PX_SCHED_COLOR_EN
      if ({1'b0, field} >= {thresh, 1'b0}) begin
         return COL_WHITE;
      end else if (field >= thresh) begin
         return COL_ORANGE;
      end else if (field >= (thresh >> 1)) begin
         return COL_DIM;
      end else begin
         return COL_BLACK;
      end
`else
      return (field >= thresh) ? COL_WHITE : COL_BLACK;
`endif
   endfunction

endpackage

// File: rtl/px_sched.sv
// Metaball pixel scheduler: walks every pixel of a COLS x ROWS frame
// (column-major, y inner), strobes the evaluators, waits for all results,
// writes the thresholded colour into the back buffer and swaps buffers at
// the end of each frame. Movement requests are held until the swap so the
// balls never move part-way through a frame.
// Optional build macro: PX_SCHED_COLOR_EN (colour ramp instead of mono).
module px_sched
   import px_sched_pkg::*;
#(
   parameter int          N_BALLS = 2,
   parameter int          COLS    = 32,
   parameter int          ROWS    = 64,
   parameter logic [31:0] THRESH  = 32'h0000_8000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               mov_req,
   input  logic [N_BALLS-1:0] vld,
   input  logic [31:0]        sum,
   output logic               px_stb,
   output logic [31:0]        p_x,
   output logic [31:0]        p_y,
   output logic               mov_en,
   output logic               w_en,
   output logic [9:0]         w_addr,
   output logic               w_mask,
   output logic [11:0]        din,
   output logic               swap_en,
   output logic               busy
);

   localparam logic [10:0] PIX_LAST = 11'(COLS * ROWS - 1);
   localparam logic [31:0] Y_LAST   = STEP * 32'(ROWS - 1);

   state_t      state_q;
   logic [31:0] p_x_q, p_y_q;
   logic [31:0] p_x_d, p_y_d;
   logic [10:0] k_q, k_d;
   logic        last_px;
   logic        pend_q, pend_d;
   logic [11:0] din_q, din_d;
   logic        px_stb_q, w_en_q, w_mask_q, swap_en_q, mov_en_q, busy_q;
   logic [9:0]  w_addr_q;

   // Next pixel position: y steps fastest, x steps when y wraps, and the
   // whole walk returns to the origin after the last pixel of the frame.
   always_comb begin
      last_px = (k_q == PIX_LAST);
      p_x_d   = p_x_q;
      p_y_d   = p_y_q + STEP;
      k_d     = k_q + 11'd1;
      if (last_px) begin
         p_x_d = '0;
         p_y_d = '0;
         k_d   = '0;
      end else if (p_y_q == Y_LAST) begin
         p_x_d = p_x_q + STEP;
         p_y_d = '0;
      end
   end

   // Pending movement: any request latches it, the swap consumes it, but a
   // request landing on the swap cycle itself survives into the next frame.
   always_comb begin
      din_d  = color_map(sum, THRESH);
      pend_d = pend_q | mov_req;
      if (state_q == SWAP) begin
         pend_d = mov_req;
      end
   end

   // Frame sequencer; every strobe is registered on the transition into the
   // state it belongs to so the outputs are glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         p_x_q     <= '0;
         p_y_q     <= '0;
         k_q       <= '0;
         pend_q    <= 1'b0;
         din_q     <= '0;
         px_stb_q  <= 1'b0;
         w_en_q    <= 1'b0;
         w_addr_q  <= '0;
         w_mask_q  <= 1'b0;
         swap_en_q <= 1'b0;
         mov_en_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         px_stb_q  <= 1'b0;
         w_en_q    <= 1'b0;
         swap_en_q <= 1'b0;
         mov_en_q  <= 1'b0;
         pend_q    <= pend_d;
         case (state_q)
            IDLE: begin
               if (run) begin
                  state_q  <= ISSUE;
                  px_stb_q <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            ISSUE: begin
               state_q <= GUARD;
            end
            GUARD: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (&vld) begin
                  state_q  <= WRITE;
                  din_q    <= din_d;
                  w_en_q   <= 1'b1;
                  w_addr_q <= k_q[9:0];
                  w_mask_q <= k_q[10];
               end
            end
            WRITE: begin
               p_x_q <= p_x_d;
               p_y_q <= p_y_d;
               k_q   <= k_d;
               if (last_px) begin
                  state_q   <= SWAP;
                  swap_en_q <= 1'b1;
                  mov_en_q  <= pend_d;
               end else begin
                  state_q  <= ISSUE;
                  px_stb_q <= 1'b1;
               end
            end
            SWAP: begin
               if (run) begin
                  state_q  <= ISSUE;
                  px_stb_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign px_stb  = px_stb_q;
   assign p_x     = p_x_q;
   assign p_y     = p_y_q;
   assign mov_en  = mov_en_q;
   assign w_en    = w_en_q;
   assign w_addr  = w_addr_q;
   assign w_mask  = w_mask_q;
   assign din     = din_q;
   assign swap_en = swap_en_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_px_sched.sv
// Self-checking bench for px_sched. Expected pixels, addresses and colours
// come from a plain arithmetic model of the frame walk (k -> x,y,addr,mask)
// and the threshold rules; movement is tracked as a single pending flag.
module tb_px_sched;

   localparam int          N_BALLS = 2;
   localparam int          COLS    = 32;
   localparam int          ROWS    = 64;
   localparam logic [31:0] THRESH  = 32'h0000_8000;

   logic               clk = 1'b0;
   logic               rst;
   logic               run;
   logic               mov_req;
   logic [N_BALLS-1:0] vld;
   logic [31:0]        sum;
   logic               px_stb;
   logic [31:0]        p_x, p_y;
   logic               mov_en, w_en, w_mask, swap_en, busy;
   logic [9:0]         w_addr;
   logic [11:0]        din;

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   px_sched #(
      .N_BALLS(N_BALLS), .COLS(COLS), .ROWS(ROWS), .THRESH(THRESH)
   ) dut (
      .clk(clk), .rst(rst), .run(run), .mov_req(mov_req), .vld(vld),
      .sum(sum), .px_stb(px_stb), .p_x(p_x), .p_y(p_y), .mov_en(mov_en),
      .w_en(w_en), .w_addr(w_addr), .w_mask(w_mask), .din(din),
      .swap_en(swap_en), .busy(busy)
   );

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   // Advance one cycle and settle just after the rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference colour for a given field value.
   function automatic logic [11:0] model_din(input logic [31:0] s);
      longint sv;
      longint th;
      sv = longint'(s);
      th = longint'(THRESH);
`ifdef PX_SCHED_COLOR_EN
      if (sv >= 2 * th) return 12'hfff;
      if (sv >= th) return 12'hf40;
      if (sv >= th / 2) return 12'h100;
      return 12'h000;
`else
      return (sv >= th) ? 12'hfff : 12'h000;
`endif
   endfunction

   // Reference pixel coordinates for linear pixel index k.
   function automatic logic [31:0] model_px(input int k);
      return 32'((k / ROWS) * 32768);
   endfunction

   function automatic logic [31:0] model_py(input int k);
      return 32'((k % ROWS) * 32768);
   endfunction

   // Field values clustered around the decision boundaries.
   function automatic logic [31:0] pick_sum();
      case ($urandom_range(0, 6))
         0: return THRESH - 32'd1;
         1: return THRESH;
         2: return THRESH + 32'd1;
         3: return THRESH / 2;
         4: return THRESH * 2;
         5: return (THRESH / 2) - 32'd1;
         default: return $urandom;
      endcase
   endfunction

   task automatic applyStimulus(input logic r, input logic go, input logic [1:0] v);
      rst = r;
      run = go;
      vld = v;
   endtask

   task automatic test_reset;
      bit bad;
      applyStimulus(1'b1, 1'b0, 2'b00);
      mov_req = 1'b0;
      sum     = 32'hffff_ffff;
      repeat (3) tick();
      checks++; if (px_stb !== 1'b0) $display("[TB] FAIL reset_px_stb got %b want 0", px_stb); else passed++;
      checks++; if (w_en !== 1'b0) $display("[TB] FAIL reset_w_en got %b want 0", w_en); else passed++;
      checks++; if (w_addr !== 10'd0) $display("[TB] FAIL reset_w_addr got %0d want 0", w_addr); else passed++;
      checks++; if (w_mask !== 1'b0) $display("[TB] FAIL reset_w_mask got %b want 0", w_mask); else passed++;
      checks++; if (din !== 12'h000) $display("[TB] FAIL reset_din got %h want 000", din); else passed++;
      checks++; if (swap_en !== 1'b0 || mov_en !== 1'b0) $display("[TB] FAIL reset_swap_mov got %b%b want 00", swap_en, mov_en); else passed++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
      checks++; if (p_x !== 32'd0 || p_y !== 32'd0) $display("[TB] FAIL reset_pxy got %h,%h want 0,0", p_x, p_y); else passed++;
      rst = 1'b0;
      bad = 1'b0;
      repeat (8) begin
         tick();
         if (busy !== 1'b0 || px_stb !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) $display("[TB] FAIL idle_hold got busy/px_stb active want quiet with run=0"); else passed++;
   endtask

   task automatic test_full_frame;
      int          k = 0;
      int          stb_cyc = -100;
      int          wen_cyc = -100;
      int          swaps = 0;
      int          budget = 0;
      int          errs = 0;
      logic [11:0] want;
      want = 12'h000;
      applyStimulus(1'b1, 1'b0, 2'b11);
      tick();
      applyStimulus(1'b0, 1'b1, 2'b11);
      while (swaps == 0 && budget < 12000) begin
         tick();
         budget++;
         if (px_stb === 1'b1) begin
            checks++;
            if (p_x !== model_px(k) || p_y !== model_py(k)) begin
               errs++;
               $display("[TB] FAIL frame_pxy k=%0d got %h,%h want %h,%h", k, p_x, p_y, model_px(k), model_py(k));
            end else passed++;
            sum     = pick_sum();
            want    = model_din(sum);
            stb_cyc = cyc;
         end
         if (w_en === 1'b1) begin
            checks++;
            if (w_addr !== 10'(k % 1024) || w_mask !== 1'(k / 1024) || din !== want || cyc - stb_cyc != 3) begin
               errs++;
               $display("[TB] FAIL frame_write k=%0d got addr=%0d mask=%b din=%h lat=%0d want addr=%0d mask=%0d din=%h lat=3",
                        k, w_addr, w_mask, din, cyc - stb_cyc, k % 1024, k / 1024, want);
            end else passed++;
            wen_cyc = cyc;
            k++;
         end
         if (swap_en === 1'b1) begin
            swaps++;
            checks++;
            if (k != 2048 || cyc - wen_cyc != 1) $display("[TB] FAIL frame_swap got writes=%0d gap=%0d want writes=2048 gap=1", k, cyc - wen_cyc);
            else passed++;
         end
         if (mov_en === 1'b1) begin
            checks++;
            $display("[TB] FAIL frame_mov_en got 1 want 0 without mov_req");
         end
         if (errs > 10) break;
      end
      checks++; if (swaps != 1) $display("[TB] FAIL frame_timeout got swaps=%0d want 1", swaps); else passed++;
      tick();
      checks++;
      if (px_stb !== 1'b1 || p_x !== 32'd0 || p_y !== 32'd0 || swap_en !== 1'b0)
         $display("[TB] FAIL frame_wrap got stb=%b pxy=%h,%h swap=%b want 1,0,0,0", px_stb, p_x, p_y, swap_en);
      else passed++;
   endtask

   task automatic test_stall;
      int  budget = 0;
      bit  early = 1'b0;
      applyStimulus(1'b1, 1'b0, 2'b11);
      tick();
      applyStimulus(1'b0, 1'b1, 2'b11);
      sum = THRESH;
      while (px_stb !== 1'b1 && budget < 20) begin
         tick();
         budget++;
      end
      checks++; if (px_stb !== 1'b1) $display("[TB] FAIL stall_start got px_stb=0 want 1 within 20 cycles"); else passed++;
      vld = 2'b01;
      repeat (22) begin
         tick();
         if (w_en === 1'b1) early = 1'b1;
      end
      checks++; if (early) $display("[TB] FAIL stall_hold got w_en=1 want 0 while vld=01"); else passed++;
      vld = 2'b11;
      tick();
      checks++;
      if (w_en !== 1'b1 || w_addr !== 10'd0 || din !== model_din(THRESH))
         $display("[TB] FAIL stall_release got w_en=%b addr=%0d din=%h want 1,0,%h", w_en, w_addr, din, model_din(THRESH));
      else passed++;
      tick();
      checks++; if (w_en !== 1'b0) $display("[TB] FAIL stall_single got w_en=%b want 0", w_en); else passed++;
   endtask

   task automatic test_threshold;
      logic [31:0] table_v [8];
      int          idx = 0;
      int          budget = 0;
      logic [11:0] want;
      table_v = '{32'h7fff, 32'h8000, 32'h0, 32'hffff_ffff, 32'h4000, 32'h3fff, 32'hffff, 32'h10000};
      want = 12'h000;
      applyStimulus(1'b1, 1'b0, 2'b11);
      tick();
      applyStimulus(1'b0, 1'b1, 2'b11);
      while (idx < 8 && budget < 100) begin
         tick();
         budget++;
         if (px_stb === 1'b1) begin
            sum  = table_v[idx];
            want = model_din(sum);
         end
         if (w_en === 1'b1) begin
            checks++;
            if (din !== want) $display("[TB] FAIL thresh_din sum=%h got %h want %h", table_v[idx], din, want);
            else passed++;
            idx++;
         end
      end
      checks++; if (idx != 8) $display("[TB] FAIL thresh_timeout got %0d writes want 8", idx); else passed++;
   endtask

   task automatic test_movement_run_drop;
      int k = 0;
      int swaps = 0;
      int budget = 0;
      int picks [3];
      bit pend_m = 1'b0;
      bit bad = 1'b0;
      for (int i = 0; i < 3; i++) picks[i] = 100 + i * 600 + $urandom_range(0, 400);
      applyStimulus(1'b1, 1'b0, 2'b11);
      mov_req = 1'b0;
      tick();
      applyStimulus(1'b0, 1'b1, 2'b11);
      while (swaps < 3 && budget < 30000) begin
         tick();
         budget++;
         mov_req = 1'b0;
         if (mov_en === 1'b1 && swap_en !== 1'b1) begin
            checks++;
            $display("[TB] FAIL move_outside_swap got mov_en=1 want 0 at k=%0d", k);
         end
         if (w_en === 1'b1) begin
            if (swaps == 0 && (k == picks[0] || k == picks[1] || k == picks[2])) begin
               mov_req = 1'b1;
               pend_m  = 1'b1;
            end
            if (swaps == 2 && k == 100) run = 1'b0;
            k++;
         end
         if (swap_en === 1'b1) begin
            checks++;
            if (mov_en !== pend_m || k != 2048)
               $display("[TB] FAIL move_swap%0d got mov_en=%b writes=%0d want %b,2048", swaps, mov_en, k, pend_m);
            else passed++;
            pend_m = 1'b0;
            if (swaps == 0) begin
               mov_req = 1'b1;
               pend_m  = 1'b1;
            end
            k = 0;
            swaps++;
         end
      end
      checks++; if (swaps != 3) $display("[TB] FAIL move_timeout got swaps=%0d want 3", swaps); else passed++;
      tick();
      checks++; if (busy !== 1'b0) $display("[TB] FAIL drop_busy got %b want 0", busy); else passed++;
      repeat (20) begin
         tick();
         if (busy !== 1'b0 || px_stb !== 1'b0 || w_en !== 1'b0 || swap_en !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) $display("[TB] FAIL drop_idle got activity want quiet after final swap"); else passed++;
   endtask

   task automatic test_reset_mid;
      int  k = 0;
      int  budget = 0;
      bit  got_stb = 1'b0;
      bit  got_wen = 1'b0;
      bit  bad = 1'b0;
      applyStimulus(1'b1, 1'b0, 2'b11);
      tick();
      applyStimulus(1'b0, 1'b1, 2'b11);
      while (k <= 500 && budget < 4000) begin
         tick();
         budget++;
         if (px_stb === 1'b1) sum = pick_sum();
         if (w_en === 1'b1) k++;
      end
      checks++; if (k != 501) $display("[TB] FAIL rmid_reach got writes=%0d want 501", k); else passed++;
      rst = 1'b1;
      tick();
      checks++;
      if (px_stb !== 1'b0 || w_en !== 1'b0 || swap_en !== 1'b0 || mov_en !== 1'b0 || busy !== 1'b0)
         $display("[TB] FAIL rmid_strobes got stb=%b wen=%b swap=%b mov=%b busy=%b want all 0", px_stb, w_en, swap_en, mov_en, busy);
      else passed++;
      checks++;
      if (w_addr !== 10'd0 || w_mask !== 1'b0 || din !== 12'h000 || p_x !== 32'd0 || p_y !== 32'd0)
         $display("[TB] FAIL rmid_values got addr=%0d mask=%b din=%h pxy=%h,%h want 0", w_addr, w_mask, din, p_x, p_y);
      else passed++;
      rst = 1'b0;
      budget = 0;
      while (!got_wen && budget < 30) begin
         tick();
         budget++;
         if (swap_en === 1'b1) bad = 1'b1;
         if (px_stb === 1'b1 && !got_stb) begin
            got_stb = 1'b1;
            checks++;
            if (p_x !== 32'd0 || p_y !== 32'd0) $display("[TB] FAIL rmid_restart_pxy got %h,%h want 0,0", p_x, p_y);
            else passed++;
         end
         if (w_en === 1'b1) begin
            got_wen = 1'b1;
            checks++;
            if (!got_stb || w_addr !== 10'd0 || w_mask !== 1'b0)
               $display("[TB] FAIL rmid_restart_w got stb_seen=%b addr=%0d mask=%b want 1,0,0", got_stb, w_addr, w_mask);
            else passed++;
         end
      end
      checks++; if (!got_wen || bad) $display("[TB] FAIL rmid_after got wen_seen=%b swap_seen=%b want 1,0", got_wen, bad); else passed++;
   endtask

   task automatic checkOutput;
      $display("%0d/%0d checks passed", passed, checks);
   endtask

   // Scenario sequence.
   initial begin
      rst     = 1'b1;
      run     = 1'b0;
      mov_req = 1'b0;
      vld     = '0;
      sum     = '0;
      test_reset();
      test_full_frame();
      test_stall();
      test_threshold();
      test_movement_run_drop();
      test_reset_mid();
      checkOutput();
      $finish;
   end

endmodule
